// File: rtl/chaos_pkg.sv
// Shared definitions for the chaos input/output stages: FIFO word field
// positions, frame limits, FSM state codes and the one-hot channel check.
package chaos_pkg;

  localparam int PAYLOAD_MSB = 139;
  localparam int CH_LSB      = 4;
  localparam int CNT_LSB     = 0;
  localparam int MAX_WORDS   = 8;

  localparam int PAYLOAD_W   = 128;
  localparam int CH_W        = 8;
  localparam int CNT_W       = 4;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_READ  = 3'd1;
  localparam state_t S_CHECK = 3'd2;
  localparam state_t S_SEND  = 3'd3;
  localparam state_t S_GAP   = 3'd4;

  // True when exactly one bit of the channel select is set.
  function automatic logic onehot_chk(input logic [CH_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/output_stage.sv
// Output stage: pops one frame from the FIFO, validates it, then streams its
// words to the selected channel. Optional drop counter: OUTPUT_STAGE_DROP_CNT_EN.
module output_stage
  import chaos_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 8
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [139:0]       data_from_fifo,
  input  logic               fifo_empty,
  output logic               fifo_r_enable,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  data_out,
  output logic [NUM_CH-1:0]  valid_out,
  output logic               last_out,
  output logic               ch_err,
  output logic               busy
`ifdef OUTPUT_STAGE_DROP_CNT_EN
  ,
  output logic [15:0]        drop_cnt
`endif
);

  state_t                 state_q, state_d;
  logic                   ren_q, ren_d;
  logic [PAYLOAD_W-1:0]   shift_q, shift_d;
  logic [NUM_CH-1:0]      ch_q, ch_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [NUM_CH-1:0]      valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;
  logic                   xfer;

  assign xfer = (valid_q != '0) && out_ready;

  always_comb begin
    // NOTE: every _d defaults to hold (pulses to 0) before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    ren_d   = 1'b0;
    shift_d = shift_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          ren_d   = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        shift_d = data_from_fifo[PAYLOAD_MSB -: PAYLOAD_W];
        ch_d    = data_from_fifo[CH_LSB +: NUM_CH];
        cnt_d   = data_from_fifo[CNT_LSB +: CNT_W];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cnt_q == '0 || cnt_q > CNT_W'(MAX_WORDS) || !onehot_chk(ch_q)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          valid_d = ch_q;
          data_d  = shift_q[PAYLOAD_W-1 -: DATA_W];
          last_d  = (cnt_q == CNT_W'(1));
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (last_q) begin
            valid_d = '0;
            last_d  = 1'b0;
            data_d  = '0;
            state_d = S_GAP;
          end else begin
            // cnt_q counts the words still to go, including the one on data_out.
            shift_d = shift_q << DATA_W;
            cnt_d   = cnt_q - CNT_W'(1);
            data_d  = shift_q[PAYLOAD_W-DATA_W-1 -: DATA_W];
            last_d  = (cnt_q == CNT_W'(2));
          end
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the FSM, so an
  // interrupted frame leaves nothing behind that could resurface later.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ren_q   <= 1'b0;
      shift_q <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      shift_q <= shift_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign fifo_r_enable = ren_q;
  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign last_out      = last_q;
  assign ch_err        = err_q;
  assign busy          = (state_q != S_IDLE);

`ifdef OUTPUT_STAGE_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (err_q && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule
